// File: rtl/vga_plot_arbiter.sv
// Shares one VGA pixel-write port between two requesters and a clear engine.
// Round-robin arbitration with burst lock; clear sweeps the frame one pixel per clock.
module vga_plot_arbiter #(
    parameter int          nX          = 9,
    parameter int          nY          = 8,
    parameter int          COLS        = 320,
    parameter int          ROWS        = 240,
    parameter logic [23:0] CLEAR_COLOR = 24'h000000
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    input  logic          clear_req,
    output logic          clear_busy,
    input  logic          req0,
    input  logic          lock0,
    input  logic [nX-1:0] x0,
    input  logic [nY-1:0] y0,
    input  logic [23:0]   color0,
    output logic          gnt0,
    input  logic          req1,
    input  logic          lock1,
    input  logic [nX-1:0] x1,
    input  logic [nY-1:0] y1,
    input  logic [23:0]   color1,
    output logic          gnt1,
    output logic [nX-1:0] VGA_X,
    output logic [nY-1:0] VGA_Y,
    output logic [23:0]   VGA_COLOR,
    output logic          plot
);

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1,
        CLEAR
    } state_t;

    localparam logic [nX-1:0] XMAX = nX'(COLS - 1);
    localparam logic [nY-1:0] YMAX = nY'(ROWS - 1);

    state_t        state_q, state_d;
    logic          last_q, last_d;
    logic          pend_q, pend_d;
    logic [nX-1:0] cx_q, cx_d;
    logic [nY-1:0] cy_q, cy_d;
    logic [nX-1:0] vx_q, vx_d;
    logic [nY-1:0] vy_q, vy_d;
    logic [23:0]   vc_q, vc_d;
    logic          plot_q, plot_d;
    logic          ok0, ok1;

    // Off-screen pixels are acknowledged but never written.
    assign ok0 = (32'(x0) < 32'(COLS)) && (32'(y0) < 32'(ROWS));
    assign ok1 = (32'(x1) < 32'(COLS)) && (32'(y1) < 32'(ROWS));

    assign clear_busy = pend_q || (state_q == CLEAR);
    assign VGA_X      = vx_q;
    assign VGA_Y      = vy_q;
    assign VGA_COLOR  = vc_q;
    assign plot       = plot_q;

    // Next-state, grants, clear sweep and pixel capture.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        pend_d  = pend_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        vc_d    = vc_q;
        plot_d  = 1'b0;
        gnt0    = 1'b0;
        gnt1    = 1'b0;

        if (clear_req && !clear_busy) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = CLEAR;
                    pend_d  = 1'b0;
                    cx_d    = '0;
                    cy_d    = '0;
                end else if (req0 && (!req1 || last_q)) begin
                    gnt0 = 1'b1;
                end else if (req1) begin
                    gnt1 = 1'b1;
                end
            end
            OWN0: begin
                gnt0 = req0;
                if (!lock0) begin
                    state_d = IDLE;
                end
            end
            OWN1: begin
                gnt1 = req1;
                if (!lock1) begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                vx_d   = cx_q;
                vy_d   = cy_q;
                vc_d   = CLEAR_COLOR;
                plot_d = 1'b1;
                if (cx_q == XMAX) begin
                    cx_d = '0;
                    if (cy_q == YMAX) begin
                        cy_d    = '0;
                        state_d = IDLE;
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (gnt0) begin
            last_d = 1'b0;
            if (lock0) begin
                state_d = OWN0;
            end
            if (ok0) begin
                vx_d   = x0;
                vy_d   = y0;
                vc_d   = color0;
                plot_d = 1'b1;
            end
        end

        if (gnt1) begin
            last_d = 1'b1;
            if (lock1) begin
                state_d = OWN1;
            end
            if (ok1) begin
                vx_d   = x1;
                vy_d   = y1;
                vc_d   = color1;
                plot_d = 1'b1;
            end
        end
    end

    // State and output registers; reset aborts any sweep in progress.
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            pend_q  <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            vx_q    <= '0;
            vy_q    <= '0;
            vc_q    <= '0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            pend_q  <= pend_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            vc_q    <= vc_d;
            plot_q  <= plot_d;
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Self-checking bench for vga_plot_arbiter.
// Directed scenarios plus random traffic against a behavioural model.
module tb_vga_plot_arbiter;

    localparam int COLS = 320;
    localparam int ROWS = 240;

    logic        clk = 1'b0;
    logic        Resetn;
    logic        clear_req;
    logic        clear_busy;
    logic        req0, lock0, gnt0;
    logic [8:0]  x0;
    logic [7:0]  y0;
    logic [23:0] color0;
    logic        req1, lock1, gnt1;
    logic [8:0]  x1;
    logic [7:0]  y1;
    logic [23:0] color1;
    logic [8:0]  VGA_X;
    logic [7:0]  VGA_Y;
    logic [23:0] VGA_COLOR;
    logic        plot;

    int checks = 0;
    int failures = 0;

    // model state
    int          m_owner;
    int          m_last;
    int          m_clr;
    bit          m_pend;
    logic [8:0]  ex;
    logic [7:0]  ey;
    logic [23:0] ec;
    logic        ep;

    // last step observations
    logic        obs_g0, obs_g1, exp_g0, exp_g1;
    logic [41:0] obs_pix;
    logic        obs_busy;

    vga_plot_arbiter #(
        .nX(9), .nY(8), .COLS(COLS), .ROWS(ROWS), .CLEAR_COLOR(24'h000000)
    ) dut (
        .CLOCK_50  (clk),
        .Resetn    (Resetn),
        .clear_req (clear_req),
        .clear_busy(clear_busy),
        .req0      (req0),
        .lock0     (lock0),
        .x0        (x0),
        .y0        (y0),
        .color0    (color0),
        .gnt0      (gnt0),
        .req1      (req1),
        .lock1     (lock1),
        .x1        (x1),
        .y1        (y1),
        .color1    (color1),
        .gnt1      (gnt1),
        .VGA_X     (VGA_X),
        .VGA_Y     (VGA_Y),
        .VGA_COLOR (VGA_COLOR),
        .plot      (plot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_clr   = -1;
        m_pend  = 0;
        ex = '0;
        ey = '0;
        ec = '0;
        ep = 1'b0;
    endtask

    // One clock: check grants/busy before the edge, pixel port after it.
    task automatic step();
        logic   g0, g1;
        bit     busy;
        int     g;
        logic [8:0]  gx;
        logic [7:0]  gy;
        logic [23:0] gc;
        logic        gl;
        #1;
        busy = m_pend || (m_clr >= 0);
        g0 = 1'b0;
        g1 = 1'b0;
        if (m_clr < 0) begin
            if (m_owner == 0) g0 = req0;
            else if (m_owner == 1) g1 = req1;
            else if (!m_pend) begin
                if (req0 && req1) begin
                    if (m_last == 0) g1 = 1'b1;
                    else g0 = 1'b1;
                end else begin
                    g0 = req0;
                    g1 = req1;
                end
            end
        end
        chk("gnt", 64'({gnt0, gnt1}), 64'({g0, g1}));
        chk("busy", 64'(clear_busy), 64'(busy));
        obs_g0 = gnt0;
        obs_g1 = gnt1;
        exp_g0 = g0;
        exp_g1 = g1;

        ep = 1'b0;
        g = g0 ? 0 : (g1 ? 1 : -1);
        if (m_clr >= 0) begin
            ex = 9'(m_clr % COLS);
            ey = 8'(m_clr / COLS);
            ec = 24'h000000;
            ep = 1'b1;
            m_clr++;
            if (m_clr == COLS * ROWS) m_clr = -1;
        end else if (m_owner < 0 && m_pend) begin
            m_pend = 0;
            m_clr  = 0;
        end else if (g >= 0) begin
            m_last = g;
            gx = (g == 1) ? x1 : x0;
            gy = (g == 1) ? y1 : y0;
            gc = (g == 1) ? color1 : color0;
            gl = (g == 1) ? lock1 : lock0;
            if (int'(gx) < COLS && int'(gy) < ROWS) begin
                ex = gx;
                ey = gy;
                ec = gc;
                ep = 1'b1;
            end
            m_owner = gl ? g : -1;
        end else if (m_owner >= 0) begin
            if (!((m_owner == 1) ? lock1 : lock0)) m_owner = -1;
        end
        if (clear_req && !busy) m_pend = 1;

        @(posedge clk);
        #1;
        obs_pix  = {plot, VGA_X, VGA_Y, VGA_COLOR};
        obs_busy = clear_busy;
        chk("pix", 64'(obs_pix), 64'({ep, ex, ey, ec}));
    endtask

    task automatic idle_inputs();
        clear_req = 1'b0;
        req0 = 1'b0; lock0 = 1'b0; x0 = '0; y0 = '0; color0 = '0;
        req1 = 1'b0; lock1 = 1'b0; x1 = '0; y1 = '0; color1 = '0;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        idle_inputs();
        #1;
        chk("rst", 64'({plot, VGA_X, VGA_Y, VGA_COLOR, gnt0, gnt1, clear_busy}),
            64'(0));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        Resetn = 1'b1;
    endtask

    initial begin
        int cnt, gcnt, n0, n1, colbad;
        bit done;
        logic [3:0]  seq;
        logic [16:0] first_xy, last_xy;
        logic        lastplot;

        do_reset();

        // single pixel, 1-clock latency
        req0 = 1'b1; x0 = 9'd5; y0 = 8'd7; color0 = 24'hFF0000;
        step();
        chk("t1_gnt", 64'(obs_g0), 64'(1));
        chk("t1_pix", 64'(obs_pix), 64'({1'b1, 9'd5, 8'd7, 24'hFF0000}));
        idle_inputs();
        step();
        chk("t1_nop", 64'(obs_pix[41]), 64'(0));

        // round robin from reset
        do_reset();
        req0 = 1'b1; x0 = 9'd10; y0 = 8'd10; color0 = 24'h00FF00;
        req1 = 1'b1; x1 = 9'd20; y1 = 8'd20; color1 = 24'h0000FF;
        seq = '0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            seq[3-i] = obs_g1;
            if (obs_pix[41]) cnt++;
        end
        chk("rr_seq", 64'(seq), 64'(4'b0101));
        chk("rr_plots", 64'(cnt), 64'(4));
        idle_inputs();
        step();

        // burst lock on requester 1
        req1 = 1'b1; lock1 = 1'b1; x1 = 9'd30; y1 = 8'd3; color1 = 24'h123456;
        n0 = 0; n1 = 0;
        step();
        n0 += int'(obs_g0); n1 += int'(obs_g1);
        req0 = 1'b1; x0 = 9'd40; y0 = 8'd4; color0 = 24'h654321;
        step();
        n0 += int'(obs_g0); n1 += int'(obs_g1);
        lock1 = 1'b0;
        step();
        n0 += int'(obs_g0); n1 += int'(obs_g1);
        chk("lk_g1", 64'(n1), 64'(3));
        chk("lk_g0", 64'(n0), 64'(0));
        req1 = 1'b0;
        step();
        chk("lk_next", 64'(obs_g0), 64'(1));
        idle_inputs();
        step();

        // clear requested while requester 0 owns the port
        req0 = 1'b1; lock0 = 1'b1; x0 = 9'd1; y0 = 8'd2; color0 = 24'hABCDEF;
        step();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        req1 = 1'b1; x1 = 9'd50; y1 = 8'd60; color1 = 24'h111111;
        step();
        chk("c_pend", 64'(obs_busy), 64'(1));
        chk("c_own", 64'({obs_g0, obs_g1}), 64'(2'b10));
        lock0 = 1'b0;
        step();
        chk("c_rel", 64'(obs_g0), 64'(1));
        req0 = 1'b0;
        done = 0; cnt = 0; gcnt = 0; colbad = 0; lastplot = 1'b0;
        first_xy = '1; last_xy = '1;
        for (int n = 0; n < 80000 && !done; n++) begin
            step();
            if (obs_pix[41]) begin
                if (cnt == 0) first_xy = obs_pix[40:24];
                last_xy = obs_pix[40:24];
                if (obs_pix[23:0] != 24'h0) colbad++;
                cnt++;
            end
            gcnt += int'(obs_g0) + int'(obs_g1);
            if (!obs_busy) begin
                done = 1;
                lastplot = obs_pix[41];
            end
        end
        chk("c_done", 64'(done), 64'(1));
        chk("c_count", 64'(cnt), 64'(COLS * ROWS));
        chk("c_first", 64'(first_xy), 64'({9'd0, 8'd0}));
        chk("c_last", 64'(last_xy), 64'({9'd319, 8'd239}));
        chk("c_color", 64'(colbad), 64'(0));
        chk("c_drop", 64'(lastplot), 64'(1));
        chk("c_nognt", 64'(gcnt), 64'(0));
        step();
        chk("c_after", 64'(obs_g1), 64'(1));
        idle_inputs();
        step();

        // off-screen pixel is acknowledged but not drawn
        req0 = 1'b1; x0 = 9'd320; y0 = 8'd3; color0 = 24'hFFFFFF;
        step();
        chk("oor_gnt", 64'(obs_g0), 64'(1));
        chk("oor_plot", 64'(obs_pix[41]), 64'(0));
        chk("oor_keep", 64'(obs_pix[40:0]),
            64'({9'd50, 8'd60, 24'h111111}));
        idle_inputs();
        step();

        // reset in the middle of a sweep
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        cnt = 0;
        for (int n = 0; n < 1100 && cnt < 1000; n++) begin
            step();
            if (obs_pix[41]) cnt++;
        end
        chk("m_reach", 64'(cnt), 64'(1000));
        Resetn = 1'b0;
        #1;
        chk("m_rst", 64'({plot, VGA_X, VGA_Y, VGA_COLOR, gnt0, gnt1, clear_busy}),
            64'(0));
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        Resetn = 1'b1;
        cnt = 0;
        for (int n = 0; n < 50; n++) begin
            step();
            if (obs_pix[41]) cnt++;
        end
        chk("m_noplot", 64'(cnt), 64'(0));

        // random traffic against the model
        idle_inputs();
        exp_g0 = 1'b0;
        exp_g1 = 1'b0;
        for (int n = 0; n < 2500; n++) begin
            if (!req0 || exp_g0) begin
                req0   = ($urandom_range(0, 3) != 0);
                x0     = 9'($urandom_range(0, 339));
                y0     = 8'($urandom_range(0, 249));
                color0 = 24'($urandom);
            end
            if (!req1 || exp_g1) begin
                req1   = ($urandom_range(0, 3) != 0);
                x1     = 9'($urandom_range(0, 339));
                y1     = 8'($urandom_range(0, 249));
                color1 = 24'($urandom);
            end
            lock0 = ($urandom_range(0, 3) == 0);
            lock1 = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
